// File: rtl/serializador_pkg.sv
// serializador_pkg: shared state encodings and default word width
package serializador_pkg;
  localparam int DEF_WIDTH = 16;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/serializador_if.sv
// serializador_if: word handshake and serial output bundle
interface serializador_if #(parameter int WIDTH = serializador_pkg::DEF_WIDTH);
  logic [WIDTH-1:0] D;
  logic load, en, ready, sout, sout_valid, done;
  modport master(output D, load, en, input ready, sout, sout_valid, done);
  modport slave(input D, load, en, output ready, sout, sout_valid, done);
endinterface

// File: rtl/serializador_piso_shift_reg.sv
// piso_shift_reg: parallel-in serial-out register, head bit selectable end
module piso_shift_reg #(
  parameter int WIDTH = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             head
);
  logic [WIDTH-1:0] q;
  // capture wins over shift; the vacated end fills with zero
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= MSB_FIRST != 0 ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
  assign head = MSB_FIRST != 0 ? q[WIDTH-1] : q[0];
endmodule

// File: rtl/serializador.sv
// serializador: word serializer with shift pause and one-cycle done pulse
module serializador
  import serializador_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input logic           clk,
  input logic           rst,
  serializador_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  logic [1:0] state, nxt;
  logic [CW-1:0] cnt;
  logic cap, adv, last, head;
  // capture only from IDLE; the last enabled bit hands over to DONE, code 3 falls back to IDLE
  always_comb begin
    cap = state == ST_IDLE && s.load;
    adv = state == ST_SHIFT && s.en;
    last = cnt == CW'(WIDTH - 1);
    nxt = cap ? ST_SHIFT : adv && last ? ST_DONE : state == ST_SHIFT ? ST_SHIFT : ST_IDLE;
  end
  // state and bit counter; counter holds at WIDTH-1 so it never wraps
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= cap ? '0 : adv && !last ? cnt + CW'(1) : cnt;
    end
  piso_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_piso (
    .clk(clk), .rst(rst), .load(cap), .shift(adv), .d(s.D), .head(head)
  );
  assign s.ready = state == ST_IDLE && !rst;
  assign s.sout_valid = adv;
  assign s.sout = state == ST_SHIFT && head;
  assign s.done = state == ST_DONE;
endmodule

// File: doc/serializador.md
SERIALIZADOR -- requirements
Module: serializador

Interface
REQ-001 Parameter WIDTH, default 16, word length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 emitted first, 0 = bit 0 emitted first.
REQ-003 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  reset; asynchronous, active-high.
REQ-005 Port D  input  WIDTH  parallel word to transmit.
REQ-006 Port load  input  1  request to capture D; honoured only when ready=1.
REQ-007 Port en  input  1  shift enable; 0 pauses transmission in SHIFT.
REQ-008 Port ready  output  1  block idle and able to accept a word.
REQ-009 Port sout  output  1  serial data bit.
REQ-010 Port sout_valid  output  1  sout carries a valid bit this cycle.
REQ-011 Port done  output  1  one-cycle pulse after the last bit of a word.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; 2-bit encoding IDLE=0, SHIFT=1, DONE=2; code 3 returns to IDLE on the next edge.
REQ-013 ready SHALL equal (state==IDLE) and not rst; combinational.
REQ-014 IDLE: on posedge with load=1, capture D into shift register, clear bit counter to 0, go to SHIFT; load=0 stays in IDLE.
REQ-015 Latency: first bit valid on sout in the cycle immediately after the capture edge.
REQ-016 SHIFT: sout_valid = en; sout = current head bit (MSB or LSB per MSB_FIRST), stable for the whole cycle.
REQ-017 SHIFT with en=1 at posedge: shift register advances one bit, counter increments; at counter==WIDTH-1 go to DONE instead.
REQ-018 SHIFT with en=0: shift register, counter and sout hold; sout_valid=0; no bit consumed.
REQ-019 A word SHALL produce exactly WIDTH cycles with sout_valid=1, regardless of pauses.
REQ-020 DONE: done=1, sout_valid=0, ready=0 for exactly one cycle, then IDLE unconditionally.
REQ-021 load while ready=0 SHALL be ignored with no side effects; not queued.
REQ-022 load held high continuously: next word captured on the first IDLE edge after DONE (minimum gap between words: DONE cycle plus IDLE cycle).
REQ-023 D sampled only at the capture edge; later D changes do not affect the word in flight.
REQ-024 Outside SHIFT: sout=0, sout_valid=0.
REQ-025 Bit counter width = ceil(log2(WIDTH)); never wraps during a word.

Reset
REQ-026 rst=1 forces immediately (asynchronously): state=IDLE, shift register=0, counter=0, sout=0, sout_valid=0, done=0, ready=0.
REQ-027 Reset mid-word aborts transmission; remaining bits are discarded, no done pulse.
REQ-028 After rst deasserts, ready=1 and the next posedge with load=1 captures normally.

Structure
REQ-029 Shared package holds state encodings (ST_IDLE, ST_SHIFT, ST_DONE) and default WIDTH constant.
REQ-030 One sub-module: piso_shift_reg (WIDTH-bit parallel-in serial-out register with load, shift, direction parameter, async active-high reset); FSM and counter stay in serializador.

Verification
REQ-031 MSB_FIRST=1, load D=16'hA5C3 -> sout over 16 consecutive valid cycles = 1010 0101 1100 0011; done in 17th cycle after capture; ready=1 in 18th.
REQ-032 MSB_FIRST=0, load D=16'h0001 -> first valid bit 1, next 15 bits 0; done once.
REQ-033 Load 16'hFFFF, hold en=0 for 3 cycles after bit 5 -> 19 cycles from first to last valid bit, exactly 16 valid ones, sout_valid=0 during pause.
REQ-034 During SHIFT of 16'h00FF, pulse load with D=16'h1234 -> ignored; transmitted word remains 16'h00FF.
REQ-035 Assert rst mid-cycle during bit 7 of 16'hAAAA -> sout, sout_valid, ready drop to 0 without waiting for clk; no done; after release load 16'h8001 -> correct 16-bit stream.
REQ-036 load held high with D=16'hF0F0 then 16'h0F0F -> two complete words, one done pulse each, one IDLE cycle between DONE and next first bit.
